// File: rtl/aoi22_fault_sim_sequencer.sv
// Steps the AOI22 parallel fault simulator through its 16 exhaustive vectors,
// accumulating stuck-at coverage and the first detecting vector of every fault.
module aoi22_fault_sim_sequencer #(
  parameter int NUM_NETS      = 8,
  parameter int SETTLE_CYCLES = 0,
  parameter bit EARLY_EXIT    = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  output logic [3:0]          o_vector,
  input  logic [NUM_NETS-1:0] i_detect_sa0,
  input  logic [NUM_NETS-1:0] i_detect_sa1,
  output logic                o_busy,
  output logic                o_done,
  output logic [NUM_NETS-1:0] o_covered_sa0,
  output logic [NUM_NETS-1:0] o_covered_sa1,
  output logic [4:0]          o_fault_count,
  input  logic [3:0]          i_rd_sel,
  output logic [3:0]          o_rd_vec,
  output logic                o_rd_valid
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_vector, r_settle;
  logic [NUM_NETS-1:0] r_cov_sa0, r_cov_sa1;
  logic [NUM_NETS-1:0] w_cov_sa0, w_cov_sa1;
  logic [3:0]          r_first_sa0 [NUM_NETS];
  logic [3:0]          r_first_sa1 [NUM_NETS];
  logic [4:0]          r_count, w_count;
  logic                r_done;
  logic                w_clear, w_settle_inc, w_sample, w_vec_inc, w_enter_done;

  assign w_cov_sa0 = r_cov_sa0 | i_detect_sa0;
  assign w_cov_sa1 = r_cov_sa1 | i_detect_sa1;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < NUM_NETS; i++) begin
      w_count = w_count + 5'(w_cov_sa0[i]) + 5'(w_cov_sa1[i]);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_clear      = 1'b0;
    w_settle_inc = 1'b0;
    w_sample     = 1'b0;
    w_vec_inc    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_next  = S_APPLY;
          w_clear = 1'b1;
        end
      end
      S_APPLY: begin
        if (i_abort) begin
          w_next = S_DONE;
        end else if (r_settle == 4'(SETTLE_CYCLES)) begin
          w_next = S_SAMPLE;
        end else begin
          w_settle_inc = 1'b1;
        end
      end
      S_SAMPLE: begin
        // Abort discards this vector's masks entirely.
        if (i_abort) begin
          w_next = S_DONE;
        end else begin
          w_sample = 1'b1;
          if (r_vector == 4'hF || (EARLY_EXIT && (&{w_cov_sa0, w_cov_sa1}))) begin
            w_next = S_DONE;
          end else begin
            w_next    = S_APPLY;
            w_vec_inc = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_done = (w_next == S_DONE) && o_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vector  <= '0;
      r_settle  <= '0;
      r_cov_sa0 <= '0;
      r_cov_sa1 <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      for (int i = 0; i < NUM_NETS; i++) begin
        r_first_sa0[i] <= '0;
        r_first_sa1[i] <= '0;
      end
    end else begin
      r_done <= w_enter_done;
      if (w_clear) begin
        r_vector  <= '0;
        r_settle  <= '0;
        r_cov_sa0 <= '0;
        r_cov_sa1 <= '0;
        r_count   <= '0;
        for (int i = 0; i < NUM_NETS; i++) begin
          r_first_sa0[i] <= '0;
          r_first_sa1[i] <= '0;
        end
      end else begin
        if (w_settle_inc) begin
          r_settle <= r_settle + 4'd1;
        end
        if (w_sample) begin
          r_cov_sa0 <= w_cov_sa0;
          r_cov_sa1 <= w_cov_sa1;
          r_count   <= w_count;
          // Coverage bits double as entry valid flags, so only first hits land.
          for (int i = 0; i < NUM_NETS; i++) begin
            if (i_detect_sa0[i] && !r_cov_sa0[i]) r_first_sa0[i] <= r_vector;
            if (i_detect_sa1[i] && !r_cov_sa1[i]) r_first_sa1[i] <= r_vector;
          end
        end
        if (w_vec_inc) begin
          r_vector <= r_vector + 4'd1;
          r_settle <= '0;
        end
      end
    end
  end

  always_comb begin
    o_rd_valid = 1'b0;
    o_rd_vec   = '0;
    for (int i = 0; i < NUM_NETS; i++) begin
      if (i_rd_sel[2:0] == 3'(i)) begin
        if (i_rd_sel[3]) begin
          o_rd_valid = r_cov_sa1[i];
          o_rd_vec   = r_cov_sa1[i] ? r_first_sa1[i] : 4'd0;
        end else begin
          o_rd_valid = r_cov_sa0[i];
          o_rd_vec   = r_cov_sa0[i] ? r_first_sa0[i] : 4'd0;
        end
      end
    end
  end

  assign o_vector      = r_vector;
  assign o_busy        = (r_state == S_APPLY) || (r_state == S_SAMPLE);
  assign o_done        = r_done;
  assign o_covered_sa0 = r_cov_sa0;
  assign o_covered_sa1 = r_cov_sa1;
  assign o_fault_count = r_count;

endmodule

// File: tb/tb_aoi22_fault_sim_sequencer.sv
// Bench for the AOI22 fault-sim sequencer: three parameterisations driven by a
// gate-level AOI22 fault model, stub mask tables and randomized mask tables.
module tb_aoi22_fault_sim_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  // a: SETTLE 0, no early exit; b: SETTLE 0, early exit; c: SETTLE 3, early exit
  logic       a_start, a_abort, a_busy, a_done, a_rd_valid;
  logic [3:0] a_vec, a_rd_sel, a_rd_vec;
  logic [7:0] a_det0, a_det1, a_cov0, a_cov1;
  logic [4:0] a_cnt;
  logic       b_start, b_abort, b_busy, b_done, b_rd_valid;
  logic [3:0] b_vec, b_rd_sel, b_rd_vec;
  logic [7:0] b_det0, b_det1, b_cov0, b_cov1;
  logic [4:0] b_cnt;
  logic       c_start, c_abort, c_busy, c_done, c_rd_valid;
  logic [3:0] c_vec, c_rd_sel, c_rd_vec;
  logic [7:0] c_det0, c_det1, c_cov0, c_cov1;
  logic [4:0] c_cnt;

  logic [7:0] tab0 [16];
  logic [7:0] tab1 [16];

  logic [7:0] exp_cov0, exp_cov1;
  logic [3:0] exp_first0 [8];
  logic [3:0] exp_first1 [8];
  int         exp_stop, exp_count;

  aoi22_fault_sim_sequencer #(.NUM_NETS(8), .SETTLE_CYCLES(0), .EARLY_EXIT(1'b0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_abort(a_abort), .o_vector(a_vec),
    .i_detect_sa0(a_det0), .i_detect_sa1(a_det1), .o_busy(a_busy), .o_done(a_done),
    .o_covered_sa0(a_cov0), .o_covered_sa1(a_cov1), .o_fault_count(a_cnt),
    .i_rd_sel(a_rd_sel), .o_rd_vec(a_rd_vec), .o_rd_valid(a_rd_valid));

  aoi22_fault_sim_sequencer #(.NUM_NETS(8), .SETTLE_CYCLES(0), .EARLY_EXIT(1'b1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_abort(b_abort), .o_vector(b_vec),
    .i_detect_sa0(b_det0), .i_detect_sa1(b_det1), .o_busy(b_busy), .o_done(b_done),
    .o_covered_sa0(b_cov0), .o_covered_sa1(b_cov1), .o_fault_count(b_cnt),
    .i_rd_sel(b_rd_sel), .o_rd_vec(b_rd_vec), .o_rd_valid(b_rd_valid));

  aoi22_fault_sim_sequencer #(.NUM_NETS(8), .SETTLE_CYCLES(3), .EARLY_EXIT(1'b1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(c_start), .i_abort(c_abort), .o_vector(c_vec),
    .i_detect_sa0(c_det0), .i_detect_sa1(c_det1), .o_busy(c_busy), .o_done(c_done),
    .o_covered_sa0(c_cov0), .o_covered_sa1(c_cov1), .o_fault_count(c_cnt),
    .i_rd_sel(c_rd_sel), .o_rd_vec(c_rd_vec), .o_rd_valid(c_rd_valid));

  // Nets: 0=Y, 1=A, 2=B, 3=C, 4=D, 5=A&B, 6=C&D, 7=OR feeding the inverter.
  function automatic logic aoi_eval(input logic [3:0] v, input int fnet, input logic fval);
    logic a, b, c, d, ab, cd, o, y;
    a = (fnet == 1) ? fval : v[3];
    b = (fnet == 2) ? fval : v[2];
    c = (fnet == 3) ? fval : v[1];
    d = (fnet == 4) ? fval : v[0];
    ab = (fnet == 5) ? fval : (a & b);
    cd = (fnet == 6) ? fval : (c & d);
    o  = (fnet == 7) ? fval : (ab | cd);
    y  = (fnet == 0) ? fval : ~o;
    return y;
  endfunction

  function automatic logic [7:0] aoi_mask(input logic [3:0] v, input logic pol);
    logic [7:0] m;
    m = '0;
    for (int n = 0; n < 8; n++) m[n] = aoi_eval(v, n, pol) != aoi_eval(v, -1, 1'b0);
    return m;
  endfunction

  always_comb begin
    a_det0 = tab0[a_vec];
    a_det1 = tab1[a_vec];
    b_det0 = tab0[b_vec];
    b_det1 = tab1[b_vec];
  end

  // Reference campaign over the mask tables: sticky OR, first hit, optional early stop.
  task automatic model_run(input bit ee);
    exp_cov0 = '0;
    exp_cov1 = '0;
    exp_stop = 15;
    for (int n = 0; n < 8; n++) begin
      exp_first0[n] = '0;
      exp_first1[n] = '0;
    end
    for (int v = 0; v < 16; v++) begin
      for (int n = 0; n < 8; n++) begin
        if (tab0[v][n] && !exp_cov0[n]) exp_first0[n] = 4'(v);
        if (tab1[v][n] && !exp_cov1[n]) exp_first1[n] = 4'(v);
      end
      exp_cov0 = exp_cov0 | tab0[v];
      exp_cov1 = exp_cov1 | tab1[v];
      if (ee && exp_cov0 == 8'hFF && exp_cov1 == 8'hFF) begin
        exp_stop = v;
        break;
      end
    end
    exp_count = $countones({exp_cov0, exp_cov1});
  endtask

  task automatic clear_tabs();
    for (int v = 0; v < 16; v++) begin
      tab0[v] = '0;
      tab1[v] = '0;
    end
  endtask

  task automatic pulse_start(input int inst);
    @(negedge clk);
    if (inst == 0) a_start = 1'b1; else if (inst == 1) b_start = 1'b1; else c_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    b_start = 1'b0;
    c_start = 1'b0;
  endtask

  // cycles = number of clock edges after the START edge when DONE is first seen.
  task automatic wait_done(input int inst, input int budget, output int cycles, output bit ok);
    logic d;
    ok = 1'b0;
    cycles = -1;
    for (int i = 0; i <= budget; i++) begin
      @(negedge clk);
      d = (inst == 0) ? a_done : (inst == 1) ? b_done : c_done;
      if (d) begin
        ok = 1'b1;
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({a_vec, a_busy, a_done, a_cov0, a_cov1, a_cnt} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vec=%0d busy=%b done=%b cov0=%h cov1=%h cnt=%0d, want all zero",
               a_vec, a_busy, a_done, a_cov0, a_cov1, a_cnt);
    end
    for (int s = 0; s < 16; s++) begin
      a_rd_sel = 4'(s);
      #1;
      n_tests++;
      if ({a_rd_valid, a_rd_vec} !== 5'd0) begin
        n_fail++;
        $display("FAIL reset_readback sel=%0d: got valid=%b vec=%0d, want 0/0", s, a_rd_valid, a_rd_vec);
      end
    end
  endtask

  task automatic test_aoi22();
    int cyc;
    bit ok;
    logic [3:0] want_v;
    logic want_ok;
    logic [3:0] sels [5];
    logic [3:0] vals [5];
    sels = '{4'h0, 4'h8, 4'h1, 4'h9, 4'hC};
    vals = '{4'd0, 4'd3, 4'd12, 4'd4, 4'd2};
    for (int v = 0; v < 16; v++) begin
      tab0[v] = aoi_mask(4'(v), 1'b0);
      tab1[v] = aoi_mask(4'(v), 1'b1);
    end
    model_run(1'b0);
    pulse_start(0);
    wait_done(0, 100, cyc, ok);
    n_tests++;
    if (!ok || cyc != 32) begin
      n_fail++;
      $display("FAIL aoi_done_cycle: got %0d (seen=%b), want 32", cyc, ok);
    end
    n_tests++;
    if ({a_cov0, a_cov1, a_cnt} !== {8'hFF, 8'hFF, 5'd16}) begin
      n_fail++;
      $display("FAIL aoi_coverage: got %h/%h cnt=%0d, want FF/FF cnt=16", a_cov0, a_cov1, a_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      a_rd_sel = sels[k];
      #1;
      n_tests++;
      if ({a_rd_valid, a_rd_vec} !== {1'b1, vals[k]}) begin
        n_fail++;
        $display("FAIL aoi_known_vec sel=%h: got valid=%b vec=%0d, want 1/%0d", sels[k], a_rd_valid, a_rd_vec, vals[k]);
      end
    end
    for (int s = 0; s < 16; s++) begin
      a_rd_sel = 4'(s);
      #1;
      want_ok = s[3] ? exp_cov1[s[2:0]] : exp_cov0[s[2:0]];
      want_v  = !want_ok ? 4'd0 : s[3] ? exp_first1[s[2:0]] : exp_first0[s[2:0]];
      n_tests++;
      if ({a_rd_valid, a_rd_vec} !== {want_ok, want_v}) begin
        n_fail++;
        $display("FAIL aoi_readback sel=%0d: got %b/%0d, want %b/%0d", s, a_rd_valid, a_rd_vec, want_ok, want_v);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({a_done, a_busy, a_vec} !== {1'b0, 1'b0, 4'd15}) begin
      n_fail++;
      $display("FAIL aoi_done_pulse: got done=%b busy=%b vec=%0d, want 0/0/15", a_done, a_busy, a_vec);
    end
  endtask

  task automatic test_early_exit();
    int cyc;
    bit ok;
    clear_tabs();
    tab0[5] = 8'hFF;
    tab1[5] = 8'hFF;
    pulse_start(1);
    wait_done(1, 100, cyc, ok);
    n_tests++;
    if (!ok || cyc != 12 || b_vec !== 4'd5) begin
      n_fail++;
      $display("FAIL early_exit_cycle: got cycle %0d vec=%0d, want 12 vec=5", cyc, b_vec);
    end
    n_tests++;
    if (b_cnt !== 5'd16) begin
      n_fail++;
      $display("FAIL early_exit_count: got %0d, want 16", b_cnt);
    end
    for (int s = 0; s < 16; s++) begin
      b_rd_sel = 4'(s);
      #1;
      n_tests++;
      if ({b_rd_valid, b_rd_vec} !== {1'b1, 4'd5}) begin
        n_fail++;
        $display("FAIL early_exit_vec sel=%0d: got %b/%0d, want 1/5", s, b_rd_valid, b_rd_vec);
      end
    end
  endtask

  task automatic test_first_vec();
    int cyc;
    bit ok;
    clear_tabs();
    tab0[2] = 8'h01;
    tab0[9] = 8'h01;
    pulse_start(0);
    wait_done(0, 100, cyc, ok);
    n_tests++;
    if (!ok || cyc != 32) begin
      n_fail++;
      $display("FAIL first_vec_done: got cycle %0d, want 32", cyc);
    end
    a_rd_sel = 4'h0;
    #1;
    n_tests++;
    if ({a_rd_valid, a_rd_vec, a_cnt} !== {1'b1, 4'd2, 5'd1}) begin
      n_fail++;
      $display("FAIL first_vec_keep: got valid=%b vec=%0d cnt=%0d, want 1/2/1", a_rd_valid, a_rd_vec, a_cnt);
    end
    a_rd_sel = 4'h8;
    #1;
    n_tests++;
    if ({a_rd_valid, a_rd_vec} !== 5'd0) begin
      n_fail++;
      $display("FAIL first_vec_unset: got %b/%0d, want 0/0", a_rd_valid, a_rd_vec);
    end
  endtask

  task automatic test_settle();
    int prev, h, cyc;
    bit ok;
    int runs [16];
    int bad;
    prev = -1;
    h = 0;
    ok = 1'b0;
    cyc = -1;
    bad = 0;
    for (int v = 0; v < 16; v++) runs[v] = 0;
    c_det0 = '0;
    c_det1 = '0;
    pulse_start(2);
    for (int n = 0; n <= 200; n++) begin
      @(negedge clk);
      if (c_done) begin
        ok = 1'b1;
        cyc = n;
        break;
      end
      if (int'(c_vec) != prev) begin
        prev = int'(c_vec);
        h = 0;
      end else begin
        h++;
      end
      runs[c_vec]++;
      c_det0 = (c_vec == 4'd4 && h < 3) ? 8'hFF : 8'h00;
      c_det1 = (c_vec == 4'd7 && h == 4) ? 8'h0F : 8'h00;
    end
    c_det0 = '0;
    c_det1 = '0;
    for (int v = 0; v < 16; v++) if (runs[v] != 5) bad++;
    n_tests++;
    if (!ok || cyc != 80 || bad != 0) begin
      n_fail++;
      $display("FAIL settle_timing: got done cycle %0d, %0d vectors not held 5 cycles, want 80/0", cyc, bad);
    end
    n_tests++;
    if ({c_cov0, c_cov1, c_cnt} !== {8'h00, 8'h0F, 5'd4}) begin
      n_fail++;
      $display("FAIL settle_capture: got %h/%h cnt=%0d, want 00/0F cnt=4", c_cov0, c_cov1, c_cnt);
    end
    c_rd_sel = 4'hA;
    #1;
    n_tests++;
    if ({c_rd_valid, c_rd_vec} !== {1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL settle_first_vec: got %b/%0d, want 1/7", c_rd_valid, c_rd_vec);
    end
  endtask

  task automatic test_abort();
    int cyc;
    bit ok, found;
    clear_tabs();
    tab0[6] = 8'hFF;
    tab1[3] = 8'h01;
    found = 1'b0;
    pulse_start(1);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (b_vec == 4'd6) begin
        found = 1'b1;
        break;
      end
    end
    @(negedge clk);
    b_abort = 1'b1;
    @(posedge clk);
    #1;
    b_abort = 1'b0;
    @(negedge clk);
    n_tests++;
    if (!found || {b_done, b_busy, b_vec, b_cov0, b_cov1, b_cnt} !== {1'b1, 1'b0, 4'd6, 8'h00, 8'h01, 5'd1}) begin
      n_fail++;
      $display("FAIL abort_freeze: got done=%b busy=%b vec=%0d cov=%h/%h cnt=%0d, want 1/0/6 00/01 1",
               b_done, b_busy, b_vec, b_cov0, b_cov1, b_cnt);
    end
    @(negedge clk);
    n_tests++;
    if ({b_done, b_vec} !== {1'b0, 4'd6}) begin
      n_fail++;
      $display("FAIL abort_pulse_len: got done=%b vec=%0d, want 0/6", b_done, b_vec);
    end
    b_start = 1'b1;
    b_abort = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    b_abort = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({b_busy, b_vec, b_cov0, b_cov1, b_cnt} !== {1'b1, 4'd0, 8'h00, 8'h00, 5'd0}) begin
      n_fail++;
      $display("FAIL abort_restart: got busy=%b vec=%0d cov=%h/%h cnt=%0d, want 1/0 00/00 0",
               b_busy, b_vec, b_cov0, b_cov1, b_cnt);
    end
    wait_done(1, 100, cyc, ok);
    n_tests++;
    if (!ok || b_cov0 !== 8'hFF || b_vec !== 4'd15) begin
      n_fail++;
      $display("FAIL abort_rerun: got seen=%b cov0=%h vec=%0d, want 1/FF/15", ok, b_cov0, b_vec);
    end
  endtask

  task automatic test_random();
    int cyc;
    bit ok;
    logic [3:0] want_v;
    logic want_ok;
    for (int it = 0; it < 6; it++) begin
      for (int v = 0; v < 16; v++) begin
        tab0[v] = 8'($urandom) & 8'($urandom);
        tab1[v] = 8'($urandom) & 8'($urandom);
        if (it[0]) begin
          tab0[v] = tab0[v] & 8'($urandom);
          tab1[v] = tab1[v] & 8'($urandom);
        end
      end
      model_run(1'b1);
      pulse_start(1);
      wait_done(1, 100, cyc, ok);
      n_tests++;
      if (!ok || cyc != 2 * (exp_stop + 1) || int'(b_vec) != exp_stop) begin
        n_fail++;
        $display("FAIL random_stop it=%0d: got cycle %0d vec=%0d, want %0d vec=%0d", it, cyc, b_vec, 2 * (exp_stop + 1), exp_stop);
      end
      n_tests++;
      if ({b_cov0, b_cov1} !== {exp_cov0, exp_cov1} || int'(b_cnt) != exp_count) begin
        n_fail++;
        $display("FAIL random_cov it=%0d: got %h/%h cnt=%0d, want %h/%h cnt=%0d", it, b_cov0, b_cov1, b_cnt, exp_cov0, exp_cov1, exp_count);
      end
      for (int s = 0; s < 16; s++) begin
        b_rd_sel = 4'(s);
        #1;
        want_ok = s[3] ? exp_cov1[s[2:0]] : exp_cov0[s[2:0]];
        want_v  = !want_ok ? 4'd0 : s[3] ? exp_first1[s[2:0]] : exp_first0[s[2:0]];
        n_tests++;
        if ({b_rd_valid, b_rd_vec} !== {want_ok, want_v}) begin
          n_fail++;
          $display("FAIL random_readback it=%0d sel=%0d: got %b/%0d, want %b/%0d", it, s, b_rd_valid, b_rd_vec, want_ok, want_v);
        end
      end
    end
  endtask

  task automatic test_busy_and_reset();
    bit found, saw_done;
    for (int v = 0; v < 16; v++) begin
      tab0[v] = aoi_mask(4'(v), 1'b0);
      tab1[v] = aoi_mask(4'(v), 1'b1);
    end
    pulse_start(0);
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (a_vec == 4'd3) begin
        found = 1'b1;
        break;
      end
    end
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (!found || {a_busy, a_vec} !== {1'b1, 4'd3}) begin
      n_fail++;
      $display("FAIL start_while_busy: got busy=%b vec=%0d, want 1/3", a_busy, a_vec);
    end
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (a_vec == 4'd10) begin
        found = 1'b1;
        break;
      end
    end
    rst_n = 1'b0;
    #1;
    a_rd_sel = 4'h0;
    #1;
    n_tests++;
    if (!found || {a_vec, a_busy, a_done, a_cov0, a_cov1, a_cnt, a_rd_valid} !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: got vec=%0d busy=%b done=%b cov=%h/%h cnt=%0d valid=%b, want all zero",
               a_vec, a_busy, a_done, a_cov0, a_cov1, a_cnt, a_rd_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (a_done || a_busy) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_no_done: got done/busy activity after reset, want none");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {a_start, a_abort, b_start, b_abort, c_start, c_abort} = '0;
    a_rd_sel = '0;
    b_rd_sel = '0;
    c_rd_sel = '0;
    c_det0 = '0;
    c_det1 = '0;
    clear_tabs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_aoi22();
    test_early_exit();
    test_first_vec();
    test_settle();
    test_abort();
    test_random();
    test_busy_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
